// File: rtl/rx_frame_packer.sv
// Receive-side frame packer: follows the destuffed CAN bit stream, packs header and
// data fields into bytes and writes them into the 13x8 receive buffer.
module rx_frame_packer #(
  parameter int MAX_DATA = 8
) (
  input  logic       clk,
  input  logic       rsn,
  input  logic       sof,
  input  logic       bit_en,
  input  logic       bit_val,
  input  logic       rx_abort,
  input  logic       buf_free,
  output logic [3:0] b_addr,
  output logic [7:0] b_din,
  output logic       b_wrn,
  output logic       rx_done,
  output logic       rx_overrun
);

  typedef enum logic [3:0] {
    IDLE, BASEID, SRR_RTR, IDE, EXTID, RTR_E, R1, R0, DLC, HDR_WR, DATA, DONE, SKIP
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [2:0]  hdr_idx, hdr_idx_nxt;
  logic [3:0]  byte_cnt, byte_cnt_nxt;
  logic [3:0]  n_bytes, n_bytes_nxt;
  logic [3:0]  b_addr_nxt;
  logic [7:0]  b_din_nxt;
  logic        b_wrn_nxt, rx_done_nxt, rx_overrun_nxt;

  logic [10:0] id_base, id_base_nxt;
  logic [17:0] id_ext, id_ext_nxt;
  logic        rtr, rtr_nxt, ide, ide_nxt;
  logic [3:0]  dlc, dlc_nxt;
  logic [7:0]  shreg, shreg_nxt;
  logic [28:0] id_full;
  logic [7:0]  hdr_byte;
  logic [2:0]  hdr_last;

  // Remote frames carry no data; oversized DLC codes still mean a full payload.
  function automatic logic [3:0] clamp_len(input logic [3:0] d, input logic r);
    if (r)
      return 4'd0;
    else if (int'(d) > MAX_DATA)
      return 4'(MAX_DATA);
    else
      return d;
  endfunction

  assign id_full  = {id_base, id_ext};
  assign hdr_last = ide ? 3'd4 : 3'd2;

  always_comb begin
    hdr_byte = 8'h00;
    if (ide) begin
      case (hdr_idx)
        3'd1:    hdr_byte = id_full[28:21];
        3'd2:    hdr_byte = id_full[20:13];
        3'd3:    hdr_byte = id_full[12:5];
        default: hdr_byte = {id_full[4:0], rtr, 2'b00};
      endcase
    end else begin
      case (hdr_idx)
        3'd1:    hdr_byte = id_base[10:3];
        default: hdr_byte = {id_base[2:0], rtr, 4'b0000};
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    hdr_idx_nxt    = hdr_idx;
    byte_cnt_nxt   = byte_cnt;
    n_bytes_nxt    = n_bytes;
    b_addr_nxt     = b_addr;
    b_din_nxt      = b_din;
    b_wrn_nxt      = 1'b1;
    rx_done_nxt    = 1'b0;
    rx_overrun_nxt = 1'b0;
    id_base_nxt    = id_base;
    id_ext_nxt     = id_ext;
    rtr_nxt        = rtr;
    ide_nxt        = ide;
    dlc_nxt        = dlc;
    shreg_nxt      = shreg;

    if (rx_abort) begin
      state_nxt = IDLE;
    end else if (sof) begin
      // A new SOF restarts reception from any state; the SOF bit itself is dropped.
      bit_cnt_nxt  = 5'd0;
      hdr_idx_nxt  = 3'd0;
      byte_cnt_nxt = 4'd0;
      if (buf_free) begin
        state_nxt = BASEID;
      end else begin
        state_nxt      = SKIP;
        rx_overrun_nxt = 1'b1;
      end
    end else begin
      case (state)
        BASEID: if (bit_en) begin
          id_base_nxt = {id_base[9:0], bit_val};
          if (bit_cnt == 5'd10) begin
            bit_cnt_nxt = 5'd0;
            state_nxt   = SRR_RTR;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        SRR_RTR: if (bit_en) begin
          rtr_nxt   = bit_val;
          state_nxt = IDE;
        end
        IDE: if (bit_en) begin
          ide_nxt   = bit_val;
          state_nxt = bit_val ? EXTID : R0;
        end
        EXTID: if (bit_en) begin
          id_ext_nxt = {id_ext[16:0], bit_val};
          if (bit_cnt == 5'd17) begin
            bit_cnt_nxt = 5'd0;
            state_nxt   = RTR_E;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        RTR_E: if (bit_en) begin
          rtr_nxt   = bit_val;
          state_nxt = R1;
        end
        R1: if (bit_en) state_nxt = R0;
        R0: if (bit_en) begin
          bit_cnt_nxt = 5'd0;
          state_nxt   = DLC;
        end
        DLC: if (bit_en) begin
          dlc_nxt = {dlc[2:0], bit_val};
          if (bit_cnt == 5'd3) begin
            // Frame-info byte goes out immediately, using the DLC bit arriving now.
            bit_cnt_nxt = 5'd0;
            b_wrn_nxt   = 1'b0;
            b_addr_nxt  = 4'd0;
            b_din_nxt   = {ide, rtr, 2'b00, dlc[2:0], bit_val};
            n_bytes_nxt = clamp_len({dlc[2:0], bit_val}, rtr);
            hdr_idx_nxt = 3'd1;
            state_nxt   = HDR_WR;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        HDR_WR: begin
          b_wrn_nxt   = 1'b0;
          b_addr_nxt  = {1'b0, hdr_idx};
          b_din_nxt   = hdr_byte;
          hdr_idx_nxt = hdr_idx + 3'd1;
          if (hdr_idx == hdr_last) begin
            byte_cnt_nxt = 4'd0;
            bit_cnt_nxt  = 5'd0;
            state_nxt    = (n_bytes == 4'd0) ? DONE : DATA;
          end
        end
        DATA: if (bit_en) begin
          shreg_nxt = {shreg[6:0], bit_val};
          if (bit_cnt == 5'd7) begin
            bit_cnt_nxt  = 5'd0;
            b_wrn_nxt    = 1'b0;
            b_addr_nxt   = (ide ? 4'd5 : 4'd3) + byte_cnt;
            b_din_nxt    = {shreg[6:0], bit_val};
            byte_cnt_nxt = byte_cnt + 4'd1;
            if (byte_cnt == n_bytes - 4'd1) state_nxt = DONE;
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end
        DONE: begin
          rx_done_nxt = 1'b1;
          state_nxt   = IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rsn) begin
    if (!rsn) begin
      state      <= IDLE;
      bit_cnt    <= 5'd0;
      hdr_idx    <= 3'd0;
      byte_cnt   <= 4'd0;
      n_bytes    <= 4'd0;
      b_addr     <= 4'd0;
      b_din      <= 8'h00;
      b_wrn      <= 1'b1;
      rx_done    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      hdr_idx    <= hdr_idx_nxt;
      byte_cnt   <= byte_cnt_nxt;
      n_bytes    <= n_bytes_nxt;
      b_addr     <= b_addr_nxt;
      b_din      <= b_din_nxt;
      b_wrn      <= b_wrn_nxt;
      rx_done    <= rx_done_nxt;
      rx_overrun <= rx_overrun_nxt;
    end
  end

  // Field shift registers: always rewritten before use, so no reset needed.
  always_ff @(posedge clk) begin
    id_base <= id_base_nxt;
    id_ext  <= id_ext_nxt;
    rtr     <= rtr_nxt;
    ide     <= ide_nxt;
    dlc     <= dlc_nxt;
    shreg   <= shreg_nxt;
  end

endmodule

// File: tb/tb_rx_frame_packer.sv
// Bench for rx_frame_packer: drives CAN frames bit by bit and compares buffer writes,
// rx_done and rx_overrun against byte lists and cycle stamps derived from the frame fields.
`timescale 1ns/1ps
module tb_rx_frame_packer;
  logic       clk = 1'b0, rsn = 1'b0, sof = 1'b0, bit_en = 1'b0, bit_val = 1'b0;
  logic       rx_abort = 1'b0, buf_free = 1'b1;
  logic [3:0] b_addr;
  logic [7:0] b_din;
  logic       b_wrn, rx_done, rx_overrun;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {int cyc; int a; int d;} wr_t;
  wr_t act_q[$];
  int  done_q[$];
  int  ovr_q[$];

  rx_frame_packer #(.MAX_DATA(8)) dut (
    .clk(clk), .rsn(rsn), .sof(sof), .bit_en(bit_en), .bit_val(bit_val),
    .rx_abort(rx_abort), .buf_free(buf_free), .b_addr(b_addr), .b_din(b_din),
    .b_wrn(b_wrn), .rx_done(rx_done), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b_wrn === 1'b0) act_q.push_back(mk(cyc, int'(b_addr), int'(b_din)));
    if (rx_done === 1'b1) done_q.push_back(cyc);
    if (rx_overrun === 1'b1) ovr_q.push_back(cyc);
  end

  function automatic wr_t mk(input int c, input int a, input int d);
    wr_t w;
    w.cyc = c; w.a = a; w.d = d;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap, output int t);
    @(negedge clk); bit_en = 1'b1; bit_val = b; t = cyc;
    @(negedge clk); bit_en = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_sof(input logic free, output int t);
    @(negedge clk); sof = 1'b1; buf_free = free; t = cyc;
    @(negedge clk); sof = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  // stop_byte >= 0 cuts the frame after that data byte: rx_abort, or rsn if use_rst.
  task automatic do_frame(input logic ide, input logic [28:0] id, input logic rtr,
                          input logic [3:0] dlc, input logic free, input logic [63:0] dbytes,
                          input int stop_byte, input logic use_rst);
    wr_t exp_q[$];
    int exp_done[$];
    int exp_ovr[$];
    int hb[5];
    int hlen, n, t, tsof, base, idv, r, e;
    logic [7:0] db;
    bit cut;
    act_q.delete(); done_q.delete(); ovr_q.delete();
    idv = int'(id); r = int'(rtr); e = int'(ide);
    n = (r == 1) ? 0 : ((int'(dlc) > 8) ? 8 : int'(dlc));
    hb[0] = e * 128 + r * 64 + int'(dlc);
    if (e == 1) begin
      hlen = 5; base = 5;
      hb[1] = (idv >> 21) & 255;
      hb[2] = (idv >> 13) & 255;
      hb[3] = (idv >> 5) & 255;
      hb[4] = ((idv & 31) << 3) | (r << 2);
    end else begin
      hlen = 3; base = 3;
      hb[1] = (idv & 'h7FF) >> 3;
      hb[2] = ((idv & 7) << 5) | (r << 4);
      hb[3] = 0; hb[4] = 0;
    end

    send_sof(free, tsof);
    if (!free) exp_ovr.push_back(tsof + 1);
    if (ide) begin
      for (int i = 28; i >= 18; i--) send_bit(id[i], 7, t);
      send_bit(1'b1, 7, t);
      send_bit(1'b1, 7, t);
      for (int i = 17; i >= 0; i--) send_bit(id[i], 7, t);
      send_bit(rtr, 7, t);
      send_bit(1'b0, 7, t);
      send_bit(1'b0, 7, t);
    end else begin
      for (int i = 10; i >= 0; i--) send_bit(id[i], 7, t);
      send_bit(rtr, 7, t);
      send_bit(1'b0, 7, t);
      send_bit(1'b0, 7, t);
    end
    for (int i = 3; i >= 0; i--) send_bit(dlc[i], 7, t);
    if (free) for (int k = 0; k < hlen; k++) exp_q.push_back(mk(t + 1 + k, k, hb[k]));

    cut = 0;
    for (int j = 0; j < n && !cut; j++) begin
      db = dbytes[63 - 8*j -: 8];
      for (int i = 7; i >= 0; i--)
        send_bit(db[i], (use_rst && j == stop_byte && i == 0) ? 0 : 7, t);
      if (free) exp_q.push_back(mk(t + 1, base + j, int'(db)));
      if (j == stop_byte) begin
        cut = 1;
        if (use_rst) begin
          chk("rst_pre_wrn", b_wrn, 1'b0);
          #1 rsn = 1'b0;
          #1;
          chk("rst_wrn", b_wrn, 1'b1);
          chk("rst_done", rx_done, 1'b0);
          chk("rst_addr", b_addr, 4'h0);
          chk("rst_din", b_din, 8'h00);
          repeat (2) @(negedge clk);
          rsn = 1'b1;
        end else begin
          @(negedge clk); rx_abort = 1'b1;
          @(negedge clk); rx_abort = 1'b0;
          for (int i = 0; i < 16; i++) send_bit(1'($urandom), 7, t);
        end
      end
    end
    if (!cut) begin
      for (int i = 0; i < 3; i++) send_bit(1'($urandom), 7, t);
      if (free) exp_done.push_back(exp_q[exp_q.size() - 1].cyc + 1);
    end
    repeat (12) @(negedge clk);

    chk("wr_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      chk($sformatf("wr%0d_cyc", i), act_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("wr%0d_addr", i), act_q[i].a, exp_q[i].a);
      chk($sformatf("wr%0d_data", i), act_q[i].d, exp_q[i].d);
    end
    chk("done_count", done_q.size(), exp_done.size());
    for (int i = 0; i < exp_done.size() && i < done_q.size(); i++)
      chk("done_cyc", done_q[i], exp_done[i]);
    chk("ovr_count", ovr_q.size(), exp_ovr.size());
    for (int i = 0; i < exp_ovr.size() && i < ovr_q.size(); i++)
      chk("ovr_cyc", ovr_q[i], exp_ovr[i]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_wrn", b_wrn, 1'b1);
    chk("reset_addr", b_addr, 4'h0);
    chk("reset_din", b_din, 8'h00);
    chk("reset_done", rx_done, 1'b0);
    chk("reset_ovr", rx_overrun, 1'b0);
    rsn = 1'b1;
    repeat (2) @(negedge clk);

    do_frame(1'b0, 29'h123, 1'b0, 4'd2, 1'b1, 64'hA53C_0000_0000_0000, -1, 1'b0);
    do_frame(1'b1, 29'h1ABCDEF0, 1'b1, 4'd5, 1'b1, {$urandom, $urandom}, -1, 1'b0);
    do_frame(1'b0, 29'h5A5, 1'b0, 4'd15, 1'b1, {$urandom, $urandom}, -1, 1'b0);
    do_frame(1'b0, 29'h055, 1'b0, 4'd2, 1'b0, {$urandom, $urandom}, -1, 1'b0);
    do_frame(1'b1, 29'h0000ABC, 1'b0, 4'd3, 1'b1, {$urandom, $urandom}, -1, 1'b0);
    do_frame(1'b0, 29'h2AA, 1'b0, 4'd4, 1'b1, {$urandom, $urandom}, 1, 1'b0);
    do_frame(1'b1, 29'($urandom), 1'b0, 4'd6, 1'b1, {$urandom, $urandom}, 1, 1'b1);
    do_frame(1'b0, 29'h321, 1'b0, 4'd8, 1'b1, {$urandom, $urandom}, -1, 1'b0);
    for (int f = 0; f < 16; f++)
      do_frame(1'($urandom_range(0, 1)), 29'($urandom), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'b1, {$urandom, $urandom}, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
